// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill engine and its backing memory.
package icache_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADD_WIDTH  = 12;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   function automatic int offset_bits(input int words);
      return $clog2(words);
   endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Miss, memory-read and line-fill signals of the refill engine; master is the engine side.
interface icache_refill_if
   import icache_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADD_WIDTH      = DEF_ADD_WIDTH,
   parameter int WORDS_PER_LINE = 4
);
   logic                                 miss_valid;
   logic                                 miss_ready;
   logic [ADD_WIDTH-1:0]                 miss_addr;
   logic                                 mem_rden;
   logic [ADD_WIDTH-1:0]                 mem_rdaddress;
   logic [DATA_WIDTH-1:0]                mem_data_out;
   logic                                 fill_valid;
   logic                                 fill_ready;
   logic [DATA_WIDTH*WORDS_PER_LINE-1:0] fill_line;
   logic [ADD_WIDTH-1:0]                 fill_addr;
   logic                                 busy;

   modport master (
      input  miss_valid, miss_addr, mem_data_out, fill_ready,
      output miss_ready, mem_rden, mem_rdaddress, fill_valid, fill_line, fill_addr, busy
   );

   modport slave (
      output miss_valid, miss_addr, mem_data_out, fill_ready,
      input  miss_ready, mem_rden, mem_rdaddress, fill_valid, fill_line, fill_addr, busy
   );
endinterface

// File: rtl/mem.sv
// Backing memory: one write port, one read port with single-cycle registered read latency.
module mem
   import icache_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADD_WIDTH  = DEF_ADD_WIDTH
) (
   input  logic                  clock,
   input  logic                  wren,
   input  logic [ADD_WIDTH-1:0]  wraddress,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rden,
   input  logic [ADD_WIDTH-1:0]  rdaddress,
   output logic [DATA_WIDTH-1:0] data_out
);
   logic [DATA_WIDTH-1:0] ram [2**ADD_WIDTH];

   always_ff @(posedge clock) begin
      if (wren) ram[wraddress] <= data_in;
      if (rden) data_out <= ram[rdaddress];
   end
endmodule

// File: rtl/icache_refill.sv
// Cache-line fill engine: one memory read per cycle per word, line buffer, valid/ready line handoff.
// Define ICACHE_REFILL_CWF_EN to fetch the missed word first, wrapping within the line.
module icache_refill
   import icache_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADD_WIDTH      = DEF_ADD_WIDTH,
   parameter int WORDS_PER_LINE = 4
) (
   input logic              clock,
   input logic              reset,
   icache_refill_if.master  bus
);
   localparam int OFFSET_BITS = offset_bits(WORDS_PER_LINE);
   localparam logic [OFFSET_BITS-1:0] LAST = OFFSET_BITS'(WORDS_PER_LINE - 1);
`ifdef ICACHE_REFILL_CWF_EN
   localparam bit CWF_EN = 1'b1;
`else
   localparam bit CWF_EN = 1'b0;
`endif

   state_t                                   state;
   logic [OFFSET_BITS-1:0]                   idx;
   logic [OFFSET_BITS-1:0]                   cnt;
   logic [OFFSET_BITS-1:0]                   rd_slot;
   logic                                     rd_pend;
   logic [OFFSET_BITS-1:0]                   start;
   logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line;

   assign start         = CWF_EN ? bus.miss_addr[OFFSET_BITS-1:0] : '0;
   assign bus.fill_line = line;

   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         idx               <= '0;
         cnt               <= '0;
         rd_slot           <= '0;
         rd_pend           <= 1'b0;
         line              <= '0;
         bus.miss_ready    <= 1'b1;
         bus.mem_rden      <= 1'b0;
         bus.mem_rdaddress <= '0;
         bus.fill_valid    <= 1'b0;
         bus.fill_addr     <= '0;
         bus.busy          <= 1'b0;
      end else begin
         // Memory answers one cycle after issue; the word lands in the slot it was read for.
         rd_pend <= bus.mem_rden;
         rd_slot <= bus.mem_rdaddress[OFFSET_BITS-1:0];
         if (rd_pend) line[rd_slot] <= bus.mem_data_out;

         case (state)
            IDLE: begin
               if (bus.miss_valid) begin
                  bus.fill_addr     <= {bus.miss_addr[ADD_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  bus.mem_rdaddress <= {bus.miss_addr[ADD_WIDTH-1:OFFSET_BITS], start};
                  bus.mem_rden      <= 1'b1;
                  bus.miss_ready    <= 1'b0;
                  bus.busy          <= 1'b1;
                  idx               <= start + 1'b1;
                  cnt               <= '0;
                  state             <= READ;
               end
            end
            READ: begin
               if (cnt == LAST) begin
                  bus.mem_rden <= 1'b0;
                  state        <= DRAIN;
               end else begin
                  bus.mem_rdaddress <= {bus.fill_addr[ADD_WIDTH-1:OFFSET_BITS], idx};
                  idx               <= idx + 1'b1;
                  cnt               <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               bus.fill_valid <= 1'b1;
               state          <= DONE;
            end
            DONE: begin
               if (bus.fill_ready) begin
                  bus.fill_valid <= 1'b0;
                  bus.miss_ready <= 1'b1;
                  bus.busy       <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
